sonic_vc_st_fifo_adapter: RTL and testbench

Parametrised Avalon-ST timing adapter for the SONIC VC TX/RX datapath. Absorbs an upstream source that has a nonzero ready latency into a ready-latency-0 sink through an internal circular buffer. Data, empty, error and channel widths, buffer depth and input ready latency are parameters. Adds a sticky overflow flag and an exported fill level, and accepts a write into a full buffer when a read happens in the same cycle.

---
 rtl/sonic_vc_st_fifo_adapter.sv | 125 ++++++++++++
 tb/tb_sonic_vc_st_fifo_adapter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_vc_st_fifo_adapter.sv
// sonic_vc_st_fifo_adapter
// Avalon-ST timing adapter: absorbs an upstream source with ready latency
// IN_READY_LATENCY into a ready-latency-0 sink through a DEPTH-entry circular
// buffer. Adds a sticky overflow flag and an exported fill level. A write into
// a full buffer is accepted when a read happens in the same cycle.
//
// Ports:
//   clk, reset_n          sole clock (rising edge), async active-low reset
//   in_ready              ready to upstream, asserted while fill < DEPTH-RL
//   in_valid, in_*        upstream beat and payload fields
//   out_ready             downstream ready (RL 0)
//   out_valid, out_*      downstream beat, payload falls through from buffer head
//   fill_level            number of entries held (0..DEPTH)
//   overflow              sticky, set when a beat was dropped
//   overflow_clr          synchronous clear of overflow (set wins)
module sonic_vc_st_fifo_adapter #(
   parameter int DATA_W           = 128,
   parameter int EMPTY_W          = 2,
   parameter int ERROR_W          = 1,
   parameter int CHANNEL_W        = 1,
   parameter int DEPTH            = 8,
   parameter int IN_READY_LATENCY = 0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic                       in_ready,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [ERROR_W-1:0]         in_error,
   input  logic [CHANNEL_W-1:0]       in_channel,
   input  logic                       in_startofpacket,
   input  logic                       in_endofpacket,
   input  logic [EMPTY_W-1:0]         in_empty,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [ERROR_W-1:0]         out_error,
   output logic [CHANNEL_W-1:0]       out_channel,
   output logic                       out_startofpacket,
   output logic                       out_endofpacket,
   output logic [EMPTY_W-1:0]         out_empty,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int PW = DATA_W + ERROR_W + CHANNEL_W + 2 + EMPTY_W;
   localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
   localparam logic [FW-1:0] FILL_RDY  = FW'(DEPTH - IN_READY_LATENCY);

   logic [PW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [FW-1:0] r_fill;
   logic          r_overflow;

   logic [PW-1:0] w_in_pay;
   logic [PW-1:0] w_out_pay;
   logic          w_rd;
   logic          w_wr_ok;
   logic          w_drop;
   logic [FW-1:0] w_fill_nxt;

   assign w_in_pay  = {in_data, in_error, in_channel, in_startofpacket,
                       in_endofpacket, in_empty};
   assign w_out_pay = r_mem[r_rp];

   // Handshake decode; a full buffer still accepts when the head leaves this cycle
   assign w_rd    = (r_fill != {FW{1'b0}}) & out_ready;
   assign w_wr_ok = in_valid & ((r_fill != FILL_FULL) | w_rd);
   assign w_drop  = in_valid & ~w_wr_ok;

   // Next fill count from the write/read pair
   always_comb begin
      w_fill_nxt = r_fill;
      case ({w_wr_ok, w_rd})
         2'b10:   w_fill_nxt = r_fill + FW'(1);
         2'b01:   w_fill_nxt = r_fill - FW'(1);
         default: w_fill_nxt = r_fill;
      endcase
   end

   // Buffer storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wp] <= w_in_pay;
      end
   end

   // Pointers, fill counter and sticky overflow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wp       <= {AW{1'b0}};
         r_rp       <= {AW{1'b0}};
         r_fill     <= {FW{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_rd) begin
            r_rp <= r_rp + AW'(1);
         end
         r_fill <= w_fill_nxt;
         // A drop in the same cycle as a clear keeps the flag set
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (overflow_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Flow-control outputs depend only on registered state
   assign in_ready   = (r_fill < FILL_RDY);
   assign out_valid  = (r_fill != {FW{1'b0}});
   assign fill_level = r_fill;
   assign overflow   = r_overflow;

   assign {out_data, out_error, out_channel, out_startofpacket,
           out_endofpacket, out_empty} = w_out_pay;

endmodule

// File: tb/tb_sonic_vc_st_fifo_adapter.sv
// Self-checking bench for sonic_vc_st_fifo_adapter (DEPTH 8, RL 3, DATA_W 64).
// A queue-based reference model tracks the buffer contents; one compare
// process checks every DUT output on each falling edge.
module tb_sonic_vc_st_fifo_adapter;

   localparam int DATA_W    = 64;
   localparam int EMPTY_W   = 2;
   localparam int ERROR_W   = 1;
   localparam int CHANNEL_W = 1;
   localparam int DEPTH     = 8;
   localparam int RL        = 3;
   localparam int FW        = $clog2(DEPTH) + 1;
   localparam int PW        = DATA_W + ERROR_W + CHANNEL_W + 2 + EMPTY_W;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 in_ready;
   logic                 in_valid;
   logic [DATA_W-1:0]    in_data;
   logic [ERROR_W-1:0]   in_error;
   logic [CHANNEL_W-1:0] in_channel;
   logic                 in_startofpacket;
   logic                 in_endofpacket;
   logic [EMPTY_W-1:0]   in_empty;
   logic                 out_ready;
   logic                 out_valid;
   logic [DATA_W-1:0]    out_data;
   logic [ERROR_W-1:0]   out_error;
   logic [CHANNEL_W-1:0] out_channel;
   logic                 out_startofpacket;
   logic                 out_endofpacket;
   logic [EMPTY_W-1:0]   out_empty;
   logic [FW-1:0]        fill_level;
   logic                 overflow;
   logic                 overflow_clr;

   int n_chk  = 0;
   int n_fail = 0;

   sonic_vc_st_fifo_adapter #(
      .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .ERROR_W(ERROR_W),
      .CHANNEL_W(CHANNEL_W), .DEPTH(DEPTH), .IN_READY_LATENCY(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
      .in_data(in_data), .in_error(in_error), .in_channel(in_channel),
      .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_empty(in_empty), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_error(out_error), .out_channel(out_channel),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty), .fill_level(fill_level), .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] in_pay;
   logic [PW-1:0] out_pay;
   assign in_pay  = {in_data, in_error, in_channel, in_startofpacket, in_endofpacket, in_empty};
   assign out_pay = {out_data, out_error, out_channel, out_startofpacket, out_endofpacket, out_empty};

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: a queue of accepted beats -------------
   logic [PW-1:0] mq[$];
   logic          m_ovf;
   bit            m_rd, m_wr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         m_rd = (mq.size() != 0) && out_ready;
         m_wr = in_valid && ((mq.size() < DEPTH) || m_rd);
         if (m_rd) void'(mq.pop_front());
         if (m_wr) mq.push_back(in_pay);
         if (in_valid && !m_wr) m_ovf = 1'b1;
         else if (overflow_clr) m_ovf = 1'b0;
      end
   end

   // ---------------- compare process ----------------------------------------
   logic          prev_hold = 1'b0;
   logic [PW-1:0] prev_pay;

   always @(negedge clk) begin
      chk("out_valid",  PW'(out_valid),  PW'(mq.size() != 0));
      chk("fill_level", PW'(fill_level), PW'(mq.size()));
      chk("in_ready",   PW'(in_ready),   PW'(mq.size() < (DEPTH - RL)));
      chk("overflow",   PW'(overflow),   PW'(m_ovf));
      if (mq.size() != 0) begin
         chk("payload", out_pay, mq[0]);
         if (prev_hold) chk("payload_stable", out_pay, prev_pay);
      end
      prev_hold = (mq.size() != 0) && !out_ready && reset_n;
      prev_pay  = out_pay;
   end

   // ---------------- upstream stimulus obeying ready latency ----------------
   logic [RL:0] hist;

   task automatic cyc();
      @(posedge clk);
      #2;
      hist = (hist << 1) | {{RL{1'b0}}, in_ready};
   endtask

   task automatic set_beat(input logic v, input logic [DATA_W-1:0] d);
      in_valid         = v;
      in_data          = d;
      in_error         = ERROR_W'($urandom_range(0, 1));
      in_channel       = CHANNEL_W'($urandom_range(0, 1));
      in_startofpacket = 1'($urandom_range(0, 1));
      in_endofpacket   = 1'($urandom_range(0, 1));
      in_empty         = EMPTY_W'($urandom_range(0, 3));
   endtask

   bit seen_fall;

   initial begin
      reset_n = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
      set_beat(1'b0, '0);
      hist = '1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_fill",    PW'(fill_level), PW'(0));
      chk("reset_inready", PW'(in_ready),   PW'(1));
      chk("reset_valid",   PW'(out_valid),  PW'(0));
      reset_n = 1'b1;
      cyc();

      // streaming: 64 back-to-back beats, out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         set_beat(hist[RL], DATA_W'(i));
         cyc();
         if (i == 0) begin
            chk("first_latency_valid", PW'(out_valid), PW'(1));
            chk("first_latency_data",  PW'(out_data),  PW'(0));
         end
         chk("stream_fill_le1", PW'(fill_level <= FW'(1)), PW'(1));
      end
      set_beat(1'b0, '0);
      repeat (3) cyc();

      // RL fill: out_ready low, upstream keeps sending whenever permitted
      out_ready = 1'b0;
      seen_fall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_beat(hist[RL], DATA_W'(100 + i));
         cyc();
         if (!in_ready && !seen_fall) begin
            chk("ready_fall_fill", PW'(fill_level), PW'(DEPTH - RL));
            seen_fall = 1'b1;
         end
      end
      set_beat(1'b0, '0);
      chk("rl_seen_fall", PW'(seen_fall),  PW'(1));
      chk("rl_fill_full", PW'(fill_level), PW'(8));
      chk("rl_no_ovf",    PW'(overflow),   PW'(0));

      // full with simultaneous read/write across pointer wrap
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_beat(1'b1, DATA_W'(200 + i));
         cyc();
         chk("full_rw_fill", PW'(fill_level), PW'(8));
      end
      set_beat(1'b0, '0);
      out_ready = 1'b0;
      cyc();
      chk("full_rw_no_ovf", PW'(overflow), PW'(0));

      // overflow: forced beat into a full buffer
      set_beat(1'b1, DATA_W'(300));
      cyc();
      set_beat(1'b0, '0);
      chk("ovf_set",  PW'(overflow),   PW'(1));
      chk("ovf_fill", PW'(fill_level), PW'(8));
      repeat (2) cyc();
      chk("ovf_held", PW'(overflow), PW'(1));
      overflow_clr = 1'b1;
      cyc();
      overflow_clr = 1'b0;
      chk("ovf_clr", PW'(overflow), PW'(0));
      overflow_clr = 1'b1;
      set_beat(1'b1, DATA_W'(301));
      cyc();
      overflow_clr = 1'b0;
      set_beat(1'b0, '0);
      chk("ovf_set_wins", PW'(overflow), PW'(1));

      // drain three so fill = 5, then reset mid-operation
      out_ready = 1'b1;
      repeat (3) cyc();
      out_ready = 1'b0;
      chk("pre_reset_fill", PW'(fill_level), PW'(5));
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_valid",   PW'(out_valid),  PW'(0));
      chk("midrst_fill",    PW'(fill_level), PW'(0));
      chk("midrst_inready", PW'(in_ready),   PW'(1));
      chk("midrst_ovf",     PW'(overflow),   PW'(0));
      cyc();
      reset_n = 1'b1;
      hist = '1;
      repeat (2) cyc();
      chk("post_rst_valid", PW'(out_valid), PW'(0));

      // randomized traffic with backpressure, rare RL violations and clears
      for (int i = 0; i < 3000; i++) begin
         if (hist[RL]) set_beat(1'($urandom_range(0, 9) < 7), {$urandom, $urandom});
         else          set_beat(1'($urandom_range(0, 49) == 0), {$urandom, $urandom});
         out_ready    = 1'($urandom_range(0, 9) < 6);
         overflow_clr = 1'($urandom_range(0, 39) == 0);
         cyc();
      end
      set_beat(1'b0, '0);
      overflow_clr = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + 2) cyc();
      chk("final_drained", PW'(fill_level), PW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
